// File: rtl/gyruss_audio_mixer.sv
// Time-multiplexed mixer: per-channel gain/mute, shared multiplier, saturating mono output.
// Latency CHANNELS+1 edges from strobe to out_valid; no backpressure, one sample per DIV cycles.
module gyruss_audio_mixer #(
  parameter int CHANNELS = 5,
  parameter int DIV      = 220
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [16*CHANNELS-1:0]    in,
  input  logic [8*CHANNELS-1:0]     gain,
  input  logic [CHANNELS-1:0]       mute,
  output logic signed [15:0]        out,
  output logic                      out_valid,
  output logic                      clip
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt;
  logic                     strobe;
  logic [IW-1:0]            idx;
  logic signed [27:0]       acc;
  logic [16*CHANNELS-1:0]   snap_in;
  logic [8*CHANNELS-1:0]    snap_gain;
  logic [CHANNELS-1:0]      snap_mute;

  logic signed [15:0]       sel_in;
  logic [7:0]               sel_gain;
  logic                     sel_mute;
  logic signed [24:0]       prod;
  logic signed [27:0]       s;
  logic signed [15:0]       sat_val;
  logic                     sat_clip;

  assign strobe = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (strobe) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (strobe) state_d = ACC;
      ACC:     if (idx == IW'(CHANNELS - 1)) state_d = SAT;
      SAT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Channel select for the single shared multiplier
  always_comb begin
    sel_in   = '0;
    sel_gain = '0;
    sel_mute = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == IW'(k)) begin
        sel_in   = snap_in[16*k +: 16];
        sel_gain = snap_gain[8*k +: 8];
        sel_mute = snap_mute[k];
      end
    end
  end

  assign prod = sel_mute ? 25'sd0 : 25'(sel_in) * 25'($signed({1'b0, sel_gain}));

  // Q1.7 gain: drop 7 fraction bits with floor rounding, then clamp
  assign s        = acc >>> 7;
  assign sat_clip = (s > 28'sd32767) || (s < -28'sd32768);
  assign sat_val  = (s > 28'sd32767)  ? 16'sh7fff :
                    (s < -28'sd32768) ? 16'sh8000 : s[15:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      idx       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      clip      <= 1'b0;
      snap_in   <= '0;
      snap_gain <= '0;
      snap_mute <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        IDLE: if (strobe) begin
          snap_in   <= in;
          snap_gain <= gain;
          snap_mute <= mute;
          acc       <= '0;
          idx       <= '0;
        end
        ACC: begin
          acc <= acc + 28'(prod);
          idx <= idx + IW'(1);
        end
        SAT: begin
          out       <= sat_val;
          clip      <= sat_clip;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // DIV >= CHANNELS+3 guarantees the engine is idle whenever the divider fires
  strobe_only_in_idle: assert property (@(posedge clk) disable iff (!reset) strobe |-> state_q == IDLE);

endmodule
